// File: rtl/rpl_lease_client.sv
// rpl_lease_client: per-port client sequencer for the resource pool lock.
// Queues issue-tagged jobs, requests a resource for the head job, launches it
// on grant, holds the lease until the resource reports done, then releases.
// rpl_out_o is packed as {req, req_issue_id[ID_WIDTH-1:0], release_lock}.
// Optional feature macro: RPL_LEASE_TIMEOUT_EN (abandon requests that starve).
module rpl_lease_client #(
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned NUM_RESOURCES  = 4,
    parameter int unsigned RES_ID_WIDTH   = (NUM_RESOURCES > 1) ? $clog2(NUM_RESOURCES) : 1,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [ID_WIDTH-1:0]     job_issue_id_i,
    output logic [ID_WIDTH+1:0]     rpl_out_o,
    input  logic                    grant_i,
    input  logic [RES_ID_WIDTH-1:0] alloc_id_i,
    output logic                    res_start_o,
    output logic [RES_ID_WIDTH-1:0] res_sel_o,
    output logic [ID_WIDTH-1:0]     res_issue_id_o,
    input  logic                    res_done_i,
    output logic                    job_done_o,
    output logic [ID_WIDTH-1:0]     job_done_id_o,
    output logic                    job_abort_o,
    output logic                    lease_lost_o,
    output logic                    busy_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                req;
        logic [ID_WIDTH-1:0] req_issue_id;
        logic                release_lock;
    } rpl_req_t;

`ifdef RPL_LEASE_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_RELEASE, S_DROP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_RELEASE} state_t;
`endif

    // Elaboration-time parameter sanity checks
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end
    if (NUM_RESOURCES < 1) begin : g_bad_pool
        $error("NUM_RESOURCES must be >= 1");
    end

    logic [ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                full, empty, push, pop;
    logic [ID_WIDTH-1:0] head_id;

    state_t                  state_q, state_d;
    rpl_req_t                rpl_q, rpl_d;
    logic                    res_start_q, res_start_d;
    logic [RES_ID_WIDTH-1:0] res_sel_q, res_sel_d;
    logic [ID_WIDTH-1:0]     res_issue_id_q, res_issue_id_d;
    logic                    job_done_q, job_done_d;
    logic [ID_WIDTH-1:0]     job_done_id_q, job_done_id_d;
    logic                    lease_lost_q, lease_lost_d;
`ifdef RPL_LEASE_TIMEOUT_EN
    logic                    job_abort_q, job_abort_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
`endif

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push    = job_valid_i && !full;
    assign head_id = mem_q[rd_ptr_q];

    // Job queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Job queue storage; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= job_issue_id_i;
    end

    // Next state and next registered outputs; outputs describe the state being entered
    always_comb begin
        state_d        = state_q;
        rpl_d          = '0;
        res_start_d    = 1'b0;
        res_sel_d      = res_sel_q;
        res_issue_id_d = res_issue_id_q;
        job_done_d     = 1'b0;
        job_done_id_d  = job_done_id_q;
        lease_lost_d   = lease_lost_q;
        pop            = 1'b0;
`ifdef RPL_LEASE_TIMEOUT_EN
        job_abort_d    = 1'b0;
        wait_d         = wait_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d            = S_REQ;
                    rpl_d.req          = 1'b1;
                    rpl_d.req_issue_id = head_id;
`ifdef RPL_LEASE_TIMEOUT_EN
                    wait_d             = '0;
`endif
                end
            end
            S_REQ: begin
                rpl_d.req          = 1'b1;
                rpl_d.req_issue_id = head_id;
                if (grant_i) begin
                    state_d        = S_HOLD;
                    res_start_d    = 1'b1;
                    res_sel_d      = alloc_id_i;
                    res_issue_id_d = head_id;
                end
`ifdef RPL_LEASE_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = S_DROP;
                    rpl_d         = '0;
                    job_abort_d   = 1'b1;
                    job_done_id_d = head_id;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            S_HOLD: begin
                rpl_d.req          = 1'b1;
                rpl_d.req_issue_id = head_id;
                if (!grant_i) lease_lost_d = 1'b1;
                if (res_done_i) begin
                    state_d            = S_RELEASE;
                    rpl_d.req          = 1'b0;
                    rpl_d.release_lock = 1'b1;
                    job_done_d         = 1'b1;
                    job_done_id_d      = head_id;
                end
            end
            S_RELEASE: begin
                pop     = 1'b1;
                state_d = S_IDLE;
            end
`ifdef RPL_LEASE_TIMEOUT_EN
            S_DROP: begin
                pop     = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rpl_q          <= '0;
            res_start_q    <= 1'b0;
            res_sel_q      <= '0;
            res_issue_id_q <= '0;
            job_done_q     <= 1'b0;
            job_done_id_q  <= '0;
            lease_lost_q   <= 1'b0;
`ifdef RPL_LEASE_TIMEOUT_EN
            job_abort_q    <= 1'b0;
            wait_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rpl_q          <= rpl_d;
            res_start_q    <= res_start_d;
            res_sel_q      <= res_sel_d;
            res_issue_id_q <= res_issue_id_d;
            job_done_q     <= job_done_d;
            job_done_id_q  <= job_done_id_d;
            lease_lost_q   <= lease_lost_d;
`ifdef RPL_LEASE_TIMEOUT_EN
            job_abort_q    <= job_abort_d;
            wait_q         <= wait_d;
`endif
        end
    end

    assign job_ready_o    = !full;
    assign busy_o         = (state_q != S_IDLE) || !empty;
    assign rpl_out_o      = rpl_q;
    assign res_start_o    = res_start_q;
    assign res_sel_o      = res_sel_q;
    assign res_issue_id_o = res_issue_id_q;
    assign job_done_o     = job_done_q;
    assign job_done_id_o  = job_done_id_q;
    assign lease_lost_o   = lease_lost_q;
`ifdef RPL_LEASE_TIMEOUT_EN
    assign job_abort_o    = job_abort_q;
`else
    assign job_abort_o    = 1'b0;
`endif

endmodule

// File: tb/tb_rpl_lease_client.sv
// tb_rpl_lease_client: directed and randomized checks of rpl_lease_client
// against a transaction-level reference model (job queue plus lease phases).
module tb_rpl_lease_client;

    localparam int unsigned IDW   = 8;
    localparam int unsigned NRES  = 4;
    localparam int unsigned RESW  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            job_valid;
    logic            job_ready;
    logic [IDW-1:0]  job_issue_id;
    logic [IDW+1:0]  rpl_out;
    logic            grant;
    logic [RESW-1:0] alloc_id;
    logic            res_start;
    logic [RESW-1:0] res_sel;
    logic [IDW-1:0]  res_issue_id;
    logic            res_done;
    logic            job_done;
    logic [IDW-1:0]  job_done_id;
    logic            job_abort;
    logic            lease_lost;
    logic            busy;

    always #5 clk = ~clk;

    rpl_lease_client #(
        .ID_WIDTH      (IDW),
        .NUM_RESOURCES (NRES),
        .RES_ID_WIDTH  (RESW),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid_i   (job_valid),
        .job_ready_o   (job_ready),
        .job_issue_id_i(job_issue_id),
        .rpl_out_o     (rpl_out),
        .grant_i       (grant),
        .alloc_id_i    (alloc_id),
        .res_start_o   (res_start),
        .res_sel_o     (res_sel),
        .res_issue_id_o(res_issue_id),
        .res_done_i    (res_done),
        .job_done_o    (job_done),
        .job_done_id_o (job_done_id),
        .job_abort_o   (job_abort),
        .lease_lost_o  (lease_lost),
        .busy_o        (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: queued IDs plus lease phase flags
    logic [IDW-1:0]  mq[$];
    bit              mon_en   = 1'b0;
    bit              m_idle   = 1'b1;
    bit              m_hold   = 1'b0;
    bit              m_lost   = 1'b0;
    bit              exp_start = 1'b0;
    bit              exp_done  = 1'b0;
    bit              exp_abort = 1'b0;
    logic [RESW-1:0] exp_sel   = '0;
    int              req_run   = 0;

    // Mid-cycle model check and update
    always @(negedge clk) begin : monitor
        bit hold_now, req_exp, cur_ready, cur_start, cur_done, cur_abort, fin;
        int sz;
        sz        = mq.size();
        cur_start = exp_start;
        cur_done  = exp_done;
        cur_abort = exp_abort;
        fin       = cur_done || cur_abort;
        hold_now  = m_hold || cur_start;
        req_exp   = !m_idle && !hold_now && !fin;
        cur_ready = (sz < DEPTH);
        if (mon_en) begin
            check_eq("job_ready", 32'(job_ready), 32'(cur_ready));
            check_eq("busy", 32'(busy), 32'(sz != 0));
            check_eq("req", 32'(rpl_out[IDW+1]), 32'(req_exp || hold_now));
            check_eq("release_lock", 32'(rpl_out[0]), 32'(cur_done));
            check_eq("res_start", 32'(res_start), 32'(cur_start));
            check_eq("job_done", 32'(job_done), 32'(cur_done));
            check_eq("job_abort", 32'(job_abort), 32'(cur_abort));
            check_eq("lease_lost", 32'(lease_lost), 32'(m_lost));
            if (sz != 0) begin
                if (req_exp || hold_now) check_eq("req_issue_id", 32'(rpl_out[IDW:1]), 32'(mq[0]));
                if (hold_now)  check_eq("res_issue_id", 32'(res_issue_id), 32'(mq[0]));
                if (cur_start) check_eq("res_sel", 32'(res_sel), 32'(exp_sel));
                if (fin)       check_eq("job_done_id", 32'(job_done_id), 32'(mq[0]));
            end
        end
        if (!rst_n) begin
            mq.delete();
            m_idle    = 1'b1;
            m_hold    = 1'b0;
            m_lost    = 1'b0;
            exp_start = 1'b0;
            exp_done  = 1'b0;
            exp_abort = 1'b0;
            req_run   = 0;
        end else begin
            exp_start = req_exp && grant;
            exp_sel   = alloc_id;
            exp_done  = hold_now && res_done;
            if (hold_now && !grant) m_lost = 1'b1;
            m_hold = hold_now && !res_done;
`ifdef RPL_LEASE_TIMEOUT_EN
            if (req_exp && !grant) req_run++;
            else                   req_run = 0;
            exp_abort = (req_run >= int'(TO));
            if (exp_abort) req_run = 0;
`else
            exp_abort = 1'b0;
`endif
            if (fin)                   m_idle = 1'b1;
            else if (m_idle && sz != 0) m_idle = 1'b0;
            if (fin && sz != 0) void'(mq.pop_front());
            if (job_valid && cur_ready) mq.push_back(job_issue_id);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!res_start && n < 40) begin
            step();
            n++;
        end
        if (!res_start) check_eq(tag, 32'(res_start), 32'd1);
    endtask

    initial begin
        logic [IDW-1:0] done_ids[$];
        int starts;
        int reqc;
        int n;

        rst_n        = 1'b0;
        job_valid    = 1'b0;
        job_issue_id = '0;
        grant        = 1'b0;
        alloc_id     = '0;
        res_done     = 1'b0;
        step();
        step();
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Reset state
        check_eq("rst_rpl_out", 32'(rpl_out), 32'd0);
        check_eq("rst_res_start", 32'(res_start), 32'd0);
        check_eq("rst_job_done", 32'(job_done), 32'd0);
        check_eq("rst_lease_lost", 32'(lease_lost), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_job_ready", 32'(job_ready), 32'd1);

        // Single job, immediate grant on alloc 2, done 4 cycles after launch
        grant        = 1'b1;
        alloc_id     = 2'd2;
        job_valid    = 1'b1;
        job_issue_id = 8'h05;
        step();
        job_valid = 1'b0;
        step();
        step();
        check_eq("t1_res_start", 32'(res_start), 32'd1);
        check_eq("t1_res_sel", 32'(res_sel), 32'd2);
        check_eq("t1_res_issue_id", 32'(res_issue_id), 32'h05);
        step();
        check_eq("t1_start_pulse", 32'(res_start), 32'd0);
        step();
        step();
        step();
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        check_eq("t1_release_lock", 32'(rpl_out[0]), 32'd1);
        check_eq("t1_job_done", 32'(job_done), 32'd1);
        check_eq("t1_job_done_id", 32'(job_done_id), 32'h05);
        step();
        check_eq("t1_release_once", 32'(rpl_out[0]), 32'd0);
        check_eq("t1_idle_busy", 32'(busy), 32'd0);

        // Fill queue without grant, then drain with done in the launch cycle
        grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            job_valid    = 1'b1;
            job_issue_id = IDW'(8'h10 + i);
            step();
        end
        check_eq("t2_full_ready", 32'(job_ready), 32'd0);
        job_issue_id = 8'h14;
        step();
        step();
        check_eq("t2_fifth_held", 32'(job_ready), 32'd0);
        grant    = 1'b1;
        res_done = 1'b1;
        starts   = 0;
        n        = 0;
        while (done_ids.size() < 5 && n < 100) begin
            step();
            n++;
            if (job_ready && job_valid && job_issue_id == 8'h14) begin
                step();
                n++;
                job_valid = 1'b0;
            end
            if (res_start) starts++;
            if (job_done)  done_ids.push_back(job_done_id);
        end
        job_valid = 1'b0;
        res_done  = 1'b0;
        check_eq("t2_done_count", 32'(done_ids.size()), 32'd5);
        check_eq("t2_start_count", 32'(starts), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < done_ids.size()) check_eq("t2_order", 32'(done_ids[i]), 32'(8'h10 + i));
        end

        // Lease loss mid-HOLD, sticky until reset
        step();
        job_valid    = 1'b1;
        job_issue_id = 8'h21;
        step();
        job_valid = 1'b0;
        wait_start("t4_wait_start");
        step();
        step();
        grant = 1'b0;
        step();
        grant = 1'b1;
        check_eq("t4_lease_lost", 32'(lease_lost), 32'd1);
        step();
        step();
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        check_eq("t4_job_done", 32'(job_done), 32'd1);
        check_eq("t4_job_done_id", 32'(job_done_id), 32'h21);
        for (int i = 0; i < 5; i++) step();
        check_eq("t4_lease_sticky", 32'(lease_lost), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("t4_lease_cleared", 32'(lease_lost), 32'd0);

        // Reset while holding a lease
        job_valid    = 1'b1;
        job_issue_id = 8'h42;
        step();
        job_valid = 1'b0;
        wait_start("t5_wait_start");
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("t5_rpl_out", 32'(rpl_out), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_job_ready", 32'(job_ready), 32'd1);
        res_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t5_no_release", 32'(rpl_out[0]), 32'd0);
            check_eq("t5_no_job_done", 32'(job_done), 32'd0);
        end
        res_done = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            job_valid    = ($urandom_range(0, 2) == 0);
            job_issue_id = IDW'($urandom);
            grant        = ($urandom_range(0, 19) != 0);
            alloc_id     = RESW'($urandom_range(0, NRES - 1));
            res_done     = ($urandom_range(0, 3) == 0);
            rst_n        = (c != 750);
            step();
        end
        rst_n     = 1'b1;
        job_valid = 1'b0;
        grant     = 1'b1;
        res_done  = 1'b1;
        for (int i = 0; i < 40; i++) step();
        check_eq("drain_busy", 32'(busy), 32'd0);
        res_done = 1'b0;
        do_reset();

`ifdef RPL_LEASE_TIMEOUT_EN
        // Starved request is dropped after TO request cycles
        grant        = 1'b0;
        job_valid    = 1'b1;
        job_issue_id = 8'h33;
        step();
        job_valid = 1'b0;
        reqc = 0;
        n    = 0;
        while (!job_abort && n < 40) begin
            step();
            n++;
            if (rpl_out[IDW+1]) reqc++;
        end
        check_eq("to_abort", 32'(job_abort), 32'd1);
        check_eq("to_req_cycles", 32'(reqc), 32'(TO));
        check_eq("to_abort_id", 32'(job_done_id), 32'h33);
        check_eq("to_no_done", 32'(job_done), 32'd0);
        step();
        check_eq("to_after_abort", 32'(job_abort), 32'd0);
        check_eq("to_idle", 32'(busy), 32'd0);

        // Grant in the timeout cycle wins
        job_valid    = 1'b1;
        job_issue_id = 8'h34;
        step();
        job_valid = 1'b0;
        reqc = 0;
        n    = 0;
        while (reqc < int'(TO) && n < 40) begin
            step();
            n++;
            if (rpl_out[IDW+1]) reqc++;
        end
        grant = 1'b1;
        step();
        check_eq("to_grant_wins", 32'(res_start), 32'd1);
        check_eq("to_grant_no_abort", 32'(job_abort), 32'd0);
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        check_eq("to_grant_done_id", 32'(job_done_id), 32'h34);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rpl_lease_client.md
Name: rpl_lease_client

Overview:
- Per-port client sequencer for the resource pool lock; one instance drives one pool port.
- Queues jobs tagged with issue IDs and requests a resource for the head job.
- On grant, launches the job on the allocated resource, holds the lease until the resource reports done, then releases the lock.
- Detects lease loss and optionally abandons requests that starve.

Parameters:
ID_WIDTH, 8, issue ID width; must match the pool.
NUM_RESOURCES, 4, pool size.
RES_ID_WIDTH, (NUM_RESOURCES>1)?$clog2(NUM_RESOURCES):1, allocated resource index width.
FIFO_DEPTH, 4, job queue entries; power of two, >=2.
TIMEOUT_CYCLES, 64, request timeout; used only with the optional feature; >=1.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
job_valid  in  1  job offered
job_ready  out  1  queue can accept
job_issue_id  in  ID_WIDTH  job issue ID
rpl_out  out  rpl_req#(ID_WIDTH)::t  to pool port {req, req_issue_id, release_lock}
grant  in  1  pool grant for this port
alloc_id  in  RES_ID_WIDTH  pool allocated index
res_start  out  1  one-cycle launch pulse to resource
res_sel  out  RES_ID_WIDTH  resource being used
res_issue_id  out  ID_WIDTH  issue ID of launched job
res_done  in  1  resource finished current job
job_done  out  1  one-cycle completion pulse
job_done_id  out  ID_WIDTH  issue ID of completed/aborted job
job_abort  out  1  one-cycle abort pulse (optional feature only, else tied 0)
lease_lost  out  1  sticky error flag
busy  out  1  state != IDLE or queue non-empty

Behaviour:
Reset:
- rst_n sampled low clears FIFO, state=IDLE, lease_lost=0.
- All registered outputs are 0; rpl_out all fields 0.
- No release_lock is issued on reset; the pool shares rst_n.
- job_ready = !full, so it is 1 from the first cycle after reset.

FIFO:
- Push on job_valid&&job_ready.
- Pop only in RELEASE (or DROP). Push and pop may occur in the same cycle.
- No bypass: a job pushed into an empty queue is seen by the FSM one cycle later.
- Pointer wrap is modulo FIFO_DEPTH. Full/empty are derived from a count of width $clog2(FIFO_DEPTH)+1.

FSM states: IDLE, REQ, HOLD, RELEASE (plus DROP with the optional feature).
- IDLE:
  - rpl_out=0.
  - Go to REQ when the FIFO is non-empty.
- REQ:
  - rpl_out.req=1, req_issue_id=head ID, release_lock=0.
  - If grant=1 in this cycle: latch alloc_id into res_sel, go to HOLD.
- HOLD:
  - rpl_out.req stays 1 and req_issue_id stays the head ID.
  - res_start=1 only in the first HOLD cycle; res_issue_id=head ID is registered and stable throughout HOLD.
  - res_done is honoured from the first HOLD cycle on, including the res_start cycle. res_done=1 -> RELEASE.
  - grant=0 in any HOLD cycle sets lease_lost (sticky until reset). The FSM still waits for res_done.
- RELEASE (exactly 1 cycle):
  - rpl_out.req=0, release_lock=1.
  - Pop head; job_done=1, job_done_id=head ID.
  - Next state is IDLE; there is always one bubble before the next REQ.
- res_done is ignored outside HOLD.
- grant is ignored outside REQ/HOLD.

Latency:
- Minimum from push into an empty queue to res_start is 3 cycles: push, IDLE->REQ, grant, HOLD.
- Release follows res_done by 1 cycle.

Issue ID comparison uses wrap-around semantics in the pool; this block passes IDs through unmodified.

Optional Feature:
Macro RPL_LEASE_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering REQ and increments each REQ cycle without grant.
  - When it reaches TIMEOUT_CYCLES-1 with grant=0, next state is DROP.
  - DROP (1 cycle): rpl_out=0; pop head; job_abort=1, job_done_id=head ID; job_done stays 0. Next state is IDLE.
  - If grant=1 arrives in the timeout cycle, the grant wins (normal HOLD path).
- Not defined: no counter, no DROP state, job_abort tied 0; REQ waits indefinitely.

Test Plan:
- Reset, then push ID 0x05; pool grants alloc_id=2 on the first REQ cycle; res_done 4 cycles later -> res_start pulses 1 cycle with res_sel=2 and res_issue_id=0x05; release_lock=1 exactly 1 cycle after res_done; job_done with job_done_id=0x05.
- Push 5 jobs back-to-back with FIFO_DEPTH=4 and no grant -> job_ready=0 after the 4th push; the 5th is held until the first RELEASE pop; IDs complete in order.
- res_done asserted in the same cycle as res_start -> RELEASE in the next cycle; res_start is exactly 1 pulse.
- Drop grant for 1 cycle mid-HOLD -> lease_lost=1 and stays 1; the job still completes on res_done; lease_lost clears only on rst_n=0.
- Assert rst_n=0 during HOLD -> next cycle rpl_out=0, busy=0, FIFO empty, no release_lock or job_done pulse.
- With RPL_LEASE_TIMEOUT_EN, TIMEOUT_CYCLES=8 and grant never asserted -> after 8 REQ cycles, 1 DROP cycle with job_abort=1 and the head ID, then IDLE; a repeat run with grant at REQ cycle 8 -> HOLD, no abort.
